nios2_div_cell: RTL and testbench



---
 rtl/nios2_div_pkg.sv | 25 ++
 rtl/nios2_div_step.sv | 22 ++
 rtl/nios2_div_cell.sv | 119 +++++++++++
 tb/tb_nios2_div_cell.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/nios2_div_pkg.sv
// rtl/nios2_div_pkg.sv - shared types, defaults and helpers for the Nios II divide cell
package nios2_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int ABS_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  // Magnitude of the low w bits of v; the caller truncates back to its own width.
  function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] v,
                                                   input int w,
                                                   input logic sgn);
    logic [ABS_MAX_W-1:0] msb_mask;
    msb_mask = {{(ABS_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    if (sgn && (|(v & msb_mask))) begin
      return ~v + ABS_MAX_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/nios2_div_step.sv
// rtl/nios2_div_step.sv - one combinational restoring-division iteration
module nios2_div_step
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {rem, din};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/nios2_div_cell.sv
// rtl/nios2_div_cell.sv - iterative radix-2 div/divu cell; NIOS2_DIV_FAST_ZERO_EN short-cuts zero divisors
module nios2_div_cell
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             qsign, rsign, zero;

  logic [WIDTH-1:0] abs1, abs2;
  logic             src_zero;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign abs1     = WIDTH'(abs_val(ABS_MAX_W'(src1), WIDTH, is_signed));
  assign abs2     = WIDTH'(abs_val(ABS_MAX_W'(src2), WIDTH, is_signed));
  assign src_zero = (src2 == '0);

  nios2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef NIOS2_DIV_FAST_ZERO_EN
          state_nx = src_zero ? FIX : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // dvd shifts the dividend out of its top while quotient bits enter at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      zero      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            dvd   <= abs1;
            dvs   <= abs2;
            qsign <= (src1[WIDTH-1] ^ src2[WIDTH-1]) & is_signed;
            rsign <= src1[WIDTH-1] & is_signed;
            zero  <= src_zero;
`ifdef NIOS2_DIV_FAST_ZERO_EN
            rem   <= src_zero ? abs1 : '0;
`else
            rem   <= '0;
`endif
          end
        end
        CALC: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          // A zero divisor leaves |src1| in rem, so the sign fix restores the original dividend.
          quotient  <= zero ? '1 : (qsign ? -dvd : dvd);
          remainder <= rsign ? -rem : rem;
          div_zero  <= zero;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_div_cell.sv
// tb/tb_nios2_div_cell.sv - directed self-checking bench for nios2_div_cell
module tb_nios2_div_cell;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        ready, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_bad = 0;

  nios2_div_cell #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .src1      (src1),
    .src2      (src2),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez, input logic poke);
    int   edges;
    int   lat_exp;
    logic rdy_bad;
    lat_exp = 33;
`ifdef NIOS2_DIV_FAST_ZERO_EN
    if (b == 32'd0) lat_exp = 1;
`endif
    @(negedge clk);
    start = 1'b1; is_signed = sgn; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; is_signed = ~sgn;
    edges = 0; rdy_bad = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
      if (poke && edges == 4) begin
        start = 1'b1; src1 = 32'd1000; src2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (!done && ready) rdy_bad = 1'b1;
    end
    chk({tag, "_lat"}, edges, lat_exp);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, {31'd0, div_zero}, {31'd0, ez});
    chk({tag, "_busy"}, {31'd0, rdy_bad}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   edges;
    logic seen;

    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div("divu_100_7",  1'b0, 32'd100,      32'd7,      32'd14,       32'd2,        1'b0, 1'b0);
    run_div("div_m100_7",  1'b1, 32'hFFFFFF9C, 32'd7,      32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_div("div_100_m7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,      1'b0, 1'b0);
    run_div("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,      1'b0, 1'b0);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF, 32'd1,      32'hFFFFFFFF, 32'd0,        1'b0, 1'b0);
    run_div("div_m7_m2",   1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,      32'hFFFFFFFF, 1'b0, 1'b0);
    run_div("divu_5_9",    1'b0, 32'd5,        32'd9,      32'd0,        32'd5,        1'b0, 1'b0);
    run_div("div_zero_s",  1'b1, 32'hFFFFFF9C, 32'd0,      32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1'b0);
    run_div("div_zero_u",  1'b0, 32'h80000000, 32'd0,      32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
    run_div("ign_start",   1'b0, 32'd100,      32'd7,      32'd14,       32'd2,        1'b0, 1'b1);

    // start held high through done: the done edge itself accepts the next operands
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk);
    #1;
    src1 = 32'd1000; src2 = 32'd3;
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    chk("b2b1_lat", edges, 32'd33);
    chk("b2b1_q", quotient, 32'd14);
    chk("b2b1_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept", {31'd0, ready}, 32'd0);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    chk("b2b2_lat", edges, 32'd33);
    chk("b2b2_q", quotient, 32'd333);
    chk("b2b2_r", remainder, 32'd1);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mid_rst_nodone", {31'd0, seen}, 32'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
